// File: rtl/logic_pulser.sv
// Tri-state stimulus driver for the probed node: hi-Z, force low/high, or debounced trigger pulses.
// Optional burst mode (burst_len port, multi-pulse per trigger) is enabled by defining LOGIC_PULSER_BURST_EN.
`timescale 1ns/1ps
module logic_pulser #(
  parameter int unsigned PULSE_WIDTH    = 50,
  parameter int unsigned PERIOD_BASE    = 500,
  parameter int unsigned PERIOD_WIDTH   = 16,
  parameter int unsigned DEBOUNCE_WIDTH = 20
) (
  input  logic       clk,
  input  logic       pulse_reset,
  input  logic [1:0] mode,
  input  logic       pulse_pol,
  input  logic       trigger,
  input  logic       continuous,
  input  logic [1:0] period_sel,
`ifdef LOGIC_PULSER_BURST_EN
  input  logic [3:0] burst_len,
`endif
  output logic       drv_out,
  output logic       drv_oe,
  output logic       busy,
  output logic [7:0] pulse_count
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_PULSE = 2'd1;
  localparam logic [1:0] ST_GAP   = 2'd2;

  localparam logic [1:0] MODE_HIZ   = 2'd0;
  localparam logic [1:0] MODE_LOW   = 2'd1;
  localparam logic [1:0] MODE_HIGH  = 2'd2;
  localparam logic [1:0] MODE_PULSE = 2'd3;

  localparam logic [PERIOD_WIDTH-1:0] PW_P    = PERIOD_WIDTH'(PULSE_WIDTH);
  localparam logic [PERIOD_WIDTH-1:0] PW_LAST = PERIOD_WIDTH'(PULSE_WIDTH - 1);
  localparam logic [PERIOD_WIDTH-1:0] BASE_P  = PERIOD_WIDTH'(PERIOD_BASE);
  localparam logic [PERIOD_WIDTH-1:0] ONE_P   = PERIOD_WIDTH'(1);

  logic                      sync1, sync2;
  logic                      stable, stable_d;
  logic [DEBOUNCE_WIDTH-1:0] db_cnt;
  logic                      trig_evt;

  logic [1:0]              state, state_n;
  logic [PERIOD_WIDTH-1:0] cnt, cnt_n;
  logic [PERIOD_WIDTH-1:0] period_q, period_n;
  logic [PERIOD_WIDTH-1:0] gap_last;
  logic                    pol_q, pol_n;
  logic [7:0]              count_n;
  logic                    drv_out_n, drv_oe_n, busy_n;
  logic                    start;
`ifdef LOGIC_PULSER_BURST_EN
  logic [3:0]              burst_rem, burst_n;
`endif

  // Trigger synchronizer and debouncer: stable only follows after a full counter run of disagreement
  always_ff @(posedge clk or negedge pulse_reset) begin
    if (!pulse_reset) begin
      sync1    <= 1'b0;
      sync2    <= 1'b0;
      stable   <= 1'b0;
      stable_d <= 1'b0;
      db_cnt   <= '0;
    end else begin
      sync1    <= trigger;
      sync2    <= sync1;
      stable_d <= stable;
      if (sync2 == stable) begin
        db_cnt <= '0;
      end else if (db_cnt == '1) begin
        stable <= sync2;
        db_cnt <= '0;
      end else begin
        db_cnt <= db_cnt + DEBOUNCE_WIDTH'(1);
      end
    end
  end

  assign trig_evt = stable & ~stable_d;
  assign gap_last = period_q - PW_P - ONE_P;

  // State and registered-output update
  always_ff @(posedge clk or negedge pulse_reset) begin
    if (!pulse_reset) begin
      state       <= ST_IDLE;
      cnt         <= '0;
      period_q    <= '0;
      pol_q       <= 1'b0;
      pulse_count <= 8'd0;
      drv_out     <= 1'b0;
      drv_oe      <= 1'b0;
      busy        <= 1'b0;
`ifdef LOGIC_PULSER_BURST_EN
      burst_rem   <= 4'd0;
`endif
    end else begin
      state       <= state_n;
      cnt         <= cnt_n;
      period_q    <= period_n;
      pol_q       <= pol_n;
      pulse_count <= count_n;
      drv_out     <= drv_out_n;
      drv_oe      <= drv_oe_n;
      busy        <= busy_n;
`ifdef LOGIC_PULSER_BURST_EN
      burst_rem   <= burst_n;
`endif
    end
  end

  // Next-state, counters and next output values
  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    period_n  = period_q;
    pol_n     = pol_q;
    count_n   = pulse_count;
    start     = 1'b0;
    drv_out_n = 1'b0;
    drv_oe_n  = 1'b0;
    busy_n    = 1'b0;
`ifdef LOGIC_PULSER_BURST_EN
    burst_n   = burst_rem;
`endif

    case (state)
      ST_IDLE: begin
        cnt_n = '0;
        if (trig_evt && (mode == MODE_PULSE)) begin
          start = 1'b1;
`ifdef LOGIC_PULSER_BURST_EN
          burst_n = burst_len;
`endif
        end
      end
      ST_PULSE: begin
        if (mode != MODE_PULSE) begin
          state_n = ST_IDLE;
          cnt_n   = '0;
        end else if (cnt == PW_LAST) begin
          state_n = ST_GAP;
          cnt_n   = '0;
        end else begin
          cnt_n = cnt + ONE_P;
        end
      end
      ST_GAP: begin
        if (mode != MODE_PULSE) begin
          state_n = ST_IDLE;
          cnt_n   = '0;
        end else if (cnt == gap_last) begin
          if (continuous) begin
            start = 1'b1;
`ifdef LOGIC_PULSER_BURST_EN
          end else if (burst_rem != 4'd0) begin
            start   = 1'b1;
            burst_n = burst_rem - 4'd1;
`endif
          end else begin
            state_n = ST_IDLE;
            cnt_n   = '0;
          end
        end else begin
          cnt_n = cnt + ONE_P;
        end
      end
      default: begin
        state_n = ST_IDLE;
        cnt_n   = '0;
      end
    endcase

    // Period and polarity are captured once per pulse so a period never changes shape mid-way
    if (start) begin
      state_n  = ST_PULSE;
      cnt_n    = '0;
      period_n = BASE_P << {period_sel, 1'b0};
      pol_n    = pulse_pol;
      count_n  = pulse_count + 8'd1;
    end

    busy_n = (state_n != ST_IDLE);

    case (mode)
      MODE_HIZ: begin
        drv_oe_n  = 1'b0;
        drv_out_n = 1'b0;
      end
      MODE_LOW: begin
        drv_oe_n  = 1'b1;
        drv_out_n = 1'b0;
      end
      MODE_HIGH: begin
        drv_oe_n  = 1'b1;
        drv_out_n = 1'b1;
      end
      default: begin
        drv_oe_n = 1'b1;
        if (state_n == ST_PULSE)     drv_out_n = ~pol_n;
        else if (state_n == ST_GAP)  drv_out_n = pol_n;
        else                         drv_out_n = pulse_pol;
      end
    endcase
  end

endmodule
